guard_recovery_ctrl: RTL
========================

GUARD_RECOVERY_CTRL -- requirements
Module: guard_recovery_ctrl

Interface
REQ-001 Parameter RstHoldCycles, default 16: cycles slv_rst_o is held asserted; legal range 1..2^CntWidth-1.
REQ-002 Parameter DrainTimeout, default 256: maximum cycles in DRAIN before forcing reset; legal range 1..2^CntWidth-1.
REQ-003 Parameter ReadyTimeout, default 256: maximum cycles in WAIT_RDY before declaring failure; legal range 1..2^CntWidth-1.
REQ-004 Parameter CntWidth, default 10: width of the shared cycle counter.
REQ-005 Parameter EvtWidth, default 8: width of the recovery event counter.
REQ-006 clk_i  in  1  sole clock; all state changes on its rising edge.
REQ-007 rst_i  in  1  asynchronous, active-high reset.
REQ-008 guard_rst_req_i  in  1  reset request from the subordinate guard.
REQ-009 outstanding_i  in  1  high while any transaction is still in flight at the subordinate.
REQ-010 slv_rdy_i  in  1  subordinate reports ready after reset.
REQ-011 guard_ena_o  out  1  enables guard monitoring.
REQ-012 isolate_o  out  1  blocks new AW/AR acceptance at the guard boundary.
REQ-013 slv_rst_o  out  1  active-high reset to the subordinate.
REQ-014 rst_stat_o  out  1  single-cycle reset-clear pulse to the guard.
REQ-015 fail_o  out  1  sticky recovery failure flag.
REQ-016 busy_o  out  1  high in any state other than IDLE.
REQ-017 evt_cnt_o  out  EvtWidth  count of completed recoveries; saturates at all ones.

Function
REQ-018 The FSM SHALL have exactly six states: IDLE, DRAIN, RESET, WAIT_RDY, CLEAR and FAIL.
REQ-019 IDLE: guard_ena_o=1; all other control outputs 0; guard_rst_req_i=1 -> DRAIN on the next edge and load counter=0.
REQ-020 DRAIN: isolate_o=1, guard_ena_o=0; outstanding_i=0 or counter==DrainTimeout-1 -> RESET with counter=0; otherwise the counter increments.
REQ-021 RESET: isolate_o=1, slv_rst_o=1 for exactly RstHoldCycles cycles; counter==RstHoldCycles-1 -> WAIT_RDY with counter=0.
REQ-022 WAIT_RDY: isolate_o=1, slv_rst_o=0; slv_rdy_i=1 -> CLEAR; counter==ReadyTimeout-1 with slv_rdy_i=0 -> FAIL; slv_rdy_i has priority when both hold in the same cycle.
REQ-023 CLEAR: rst_stat_o=1 for exactly one cycle; evt_cnt_o increments (saturating) on the same edge; -> IDLE unconditionally.
REQ-024 FAIL: fail_o=1, isolate_o=1, slv_rst_o=1; the only exit is rst_i.
REQ-025 guard_rst_req_i is ignored in every state except IDLE; a request still high on the cycle after return to IDLE starts a new recovery.
REQ-026 Outputs SHALL be registered or decoded from state only, with no combinational path from any input to any output.
REQ-027 Latency from guard_rst_req_i rising in IDLE to slv_rst_o rising SHALL be 2 cycles when outstanding_i=0.
REQ-028 The counter SHALL never wrap; comparisons use the parameter minus 1, computed at CntWidth bits.

Reset
REQ-029 rst_i=1 SHALL asynchronously force state=IDLE, counter=0, evt_cnt_o=0, fail_o=0, rst_stat_o=0, slv_rst_o=0, isolate_o=0 and guard_ena_o=1.
REQ-030 Assertion of rst_i during any state, including RESET mid-hold, SHALL abort the sequence with no rst_stat_o pulse.

Structure
REQ-031 The state enum and the default timeout constants SHALL reside in the shared guard package next to the guard register types.
REQ-032 The block SHALL be flat, with no sub-modules; the saturating event counter MAY be a common_cells counter instance.

Verification
REQ-033 RstHoldCycles=4, outstanding_i=0, pulse guard_rst_req_i, slv_rdy_i=1 two cycles after slv_rst_o falls -> slv_rst_o high exactly 4 cycles, one rst_stat_o pulse, evt_cnt_o=1, guard_ena_o=1 again.
REQ-034 outstanding_i held at 1, DrainTimeout=8 -> DRAIN lasts exactly 8 cycles, then RESET is entered.
REQ-035 slv_rdy_i held at 0, ReadyTimeout=5 -> FAIL after 5 WAIT_RDY cycles, fail_o=1 sticky until rst_i, no rst_stat_o pulse.
REQ-036 rst_i asserted on the 2nd RESET cycle -> all outputs at reset values in the same cycle (asynchronous), evt_cnt_o=0.
REQ-037 EvtWidth=2 with 5 back-to-back recoveries -> evt_cnt_o saturates at 3.
REQ-038 guard_rst_req_i toggled during DRAIN, RESET and WAIT_RDY -> no effect; held high through CLEAR -> a second recovery starts from IDLE.

Source files
------------

// File: rtl/guard_recovery_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// guard_recovery_ctrl_pkg
//   Shared guard types: recovery FSM state encoding, default timeout
//   constants and the registered control-output bundle, plus the decode
//   from a state to its control-output values.
// -----------------------------------------------------------------------------
package guard_recovery_ctrl_pkg;

  localparam int unsigned DEF_RST_HOLD_CYCLES = 16;
  localparam int unsigned DEF_DRAIN_TIMEOUT   = 256;
  localparam int unsigned DEF_READY_TIMEOUT   = 256;
  localparam int unsigned DEF_CNT_WIDTH       = 10;
  localparam int unsigned DEF_EVT_WIDTH       = 8;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_DRAIN    = 3'd1,
    ST_RESET    = 3'd2,
    ST_WAIT_RDY = 3'd3,
    ST_CLEAR    = 3'd4,
    ST_FAIL     = 3'd5
  } guard_state_e;

  // Control outputs of the recovery controller, held in one register.
  typedef struct packed {
    logic guard_ena;
    logic isolate;
    logic slv_rst;
    logic rst_stat;
    logic fail;
    logic busy;
  } guard_ctrl_t;

  // Control-output values that belong to a state. The FSM loads these into
  // its output register on the same edge it enters the state, so every
  // output is a flop with no input-to-output path.
  function automatic guard_ctrl_t state_outputs(input guard_state_e st);
    guard_ctrl_t o;
    // NOTE: everything defaults to 0 first, so each branch only names the
    // bits it raises and no path leaves a bit unassigned.
    o      = '0;
    o.busy = (st != ST_IDLE);
    case (st)
      ST_DRAIN:    o.isolate = 1'b1;
      ST_RESET:    begin
                     o.isolate = 1'b1;
                     o.slv_rst = 1'b1;
                   end
      ST_WAIT_RDY: o.isolate = 1'b1;
      ST_CLEAR:    begin
                     o.isolate  = 1'b1;
                     o.rst_stat = 1'b1;
                   end
      ST_FAIL:     begin
                     o.isolate = 1'b1;
                     o.slv_rst = 1'b1;
                     o.fail    = 1'b1;
                   end
      default:     o.guard_ena = 1'b1;  // ST_IDLE and unused encodings
    endcase
    return o;
  endfunction

endpackage

// File: rtl/guard_recovery_ctrl.sv
// -----------------------------------------------------------------------------
// guard_recovery_ctrl
//   Recovers a subordinate after its guard requests a reset: isolate and
//   drain in-flight traffic, hold the subordinate in reset, wait for it to
//   report ready, then pulse a status clear to the guard. A subordinate that
//   never becomes ready parks the controller in a sticky FAIL state.
//
// Ports
//   clk_i            clock, all state changes on the rising edge
//   rst_i            asynchronous active-high reset
//   guard_rst_req_i  reset request from the guard (honoured in IDLE only)
//   outstanding_i    transactions still in flight at the subordinate
//   slv_rdy_i        subordinate ready after reset
//   guard_ena_o      enables guard monitoring
//   isolate_o        blocks new AW/AR acceptance at the guard boundary
//   slv_rst_o        active-high reset to the subordinate
//   rst_stat_o       one-cycle reset-clear pulse to the guard
//   fail_o           sticky recovery failure
//   busy_o           controller outside IDLE
//   evt_cnt_o        completed recoveries, saturating at all ones
// -----------------------------------------------------------------------------
module guard_recovery_ctrl
  import guard_recovery_ctrl_pkg::*;
#(
  parameter int unsigned RstHoldCycles = DEF_RST_HOLD_CYCLES,
  parameter int unsigned DrainTimeout  = DEF_DRAIN_TIMEOUT,
  parameter int unsigned ReadyTimeout  = DEF_READY_TIMEOUT,
  parameter int unsigned CntWidth      = DEF_CNT_WIDTH,
  parameter int unsigned EvtWidth      = DEF_EVT_WIDTH
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                guard_rst_req_i,
  input  logic                outstanding_i,
  input  logic                slv_rdy_i,
  output logic                guard_ena_o,
  output logic                isolate_o,
  output logic                slv_rst_o,
  output logic                rst_stat_o,
  output logic                fail_o,
  output logic                busy_o,
  output logic [EvtWidth-1:0] evt_cnt_o
);

  // Terminal counts at counter width; the counter restarts at 0 on every
  // state change and stops at these values, so it can never wrap.
  localparam logic [CntWidth-1:0] DrainLast = CntWidth'(DrainTimeout - 1);
  localparam logic [CntWidth-1:0] HoldLast  = CntWidth'(RstHoldCycles - 1);
  localparam logic [CntWidth-1:0] ReadyLast = CntWidth'(ReadyTimeout - 1);

  guard_state_e        r_state;
  logic [CntWidth-1:0] r_cnt;
  logic [EvtWidth-1:0] r_evt;
  guard_ctrl_t         r_ctrl;

  // NOTE: all state in this block uses non-blocking assignments so every
  // register samples the pre-edge values of the others.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_evt   <= '0;
      r_ctrl  <= state_outputs(ST_IDLE);
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (guard_rst_req_i) begin
            r_state <= ST_DRAIN;
            r_ctrl  <= state_outputs(ST_DRAIN);
            r_cnt   <= '0;
          end
        end

        ST_DRAIN: begin
          // Drained, or gave up waiting: reset the subordinate regardless.
          if (!outstanding_i || (r_cnt == DrainLast)) begin
            r_state <= ST_RESET;
            r_ctrl  <= state_outputs(ST_RESET);
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end

        ST_RESET: begin
          if (r_cnt == HoldLast) begin
            r_state <= ST_WAIT_RDY;
            r_ctrl  <= state_outputs(ST_WAIT_RDY);
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end

        ST_WAIT_RDY: begin
          // Ready wins over a timeout falling in the same cycle.
          if (slv_rdy_i) begin
            r_state <= ST_CLEAR;
            r_ctrl  <= state_outputs(ST_CLEAR);
            r_cnt   <= '0;
            // Counted as the status pulse is raised.
            if (r_evt != '1) r_evt <= r_evt + 1'b1;
          end else if (r_cnt == ReadyLast) begin
            r_state <= ST_FAIL;
            r_ctrl  <= state_outputs(ST_FAIL);
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end

        ST_CLEAR: begin
          r_state <= ST_IDLE;
          r_ctrl  <= state_outputs(ST_IDLE);
        end

        ST_FAIL: begin
          // Parked until rst_i.
        end

        default: begin
          r_state <= ST_IDLE;
          r_ctrl  <= state_outputs(ST_IDLE);
          r_cnt   <= '0;
        end
      endcase
    end
  end

  assign guard_ena_o = r_ctrl.guard_ena;
  assign isolate_o   = r_ctrl.isolate;
  assign slv_rst_o   = r_ctrl.slv_rst;
  assign rst_stat_o  = r_ctrl.rst_stat;
  assign fail_o      = r_ctrl.fail;
  assign busy_o      = r_ctrl.busy;
  assign evt_cnt_o   = r_evt;

endmodule
